// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package rr_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned ID_W  = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requester bank (master) and the arbiter (slave).
interface rr_arbiter_4_if;

   logic [rr_arb_pkg::N_REQ-1:0] req;
   logic [rr_arb_pkg::N_REQ-1:0] gnt;
   logic [rr_arb_pkg::ID_W-1:0]  gnt_id;
   logic                         gnt_valid;
   logic                         preempt;

   modport master (
      output req,
      input  gnt,
      input  gnt_id,
      input  gnt_valid,
      input  preempt
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_id,
      output gnt_valid,
      output preempt
   );

endinterface

// File: rtl/onehot_enc_4to2.sv
// One-hot to binary index encoder; all-zero input yields index 0.
module onehot_enc_4to2 (
   input  logic [3:0] onehot_i,
   output logic [1:0] idx_c_o
);

   assign idx_c_o[1] = onehot_i[2] | onehot_i[3];
   assign idx_c_o[0] = onehot_i[1] | onehot_i[3];

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with bounded hold time and a release bubble.
module rr_arbiter_4
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arbiter_4_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

   arb_state_e           state_q, state_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      owner_q, owner_d;
   logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic                 preempt_q, preempt_d;
   logic [ID_W-1:0]      sel;

   // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] pick;
      logic            found;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = ptr + ID_W'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign sel = rr_pick(bus.req, ptr_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         ptr_q      <= '0;
         owner_q    <= '0;
         hold_cnt_q <= '0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         hold_cnt_q <= hold_cnt_d;
         preempt_q  <= preempt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      preempt_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req != '0) begin
               gnt_d      = N_REQ'(1) << sel;
               owner_d    = sel;
               hold_cnt_d = CNT_W'(1);
               state_d    = BUSY;
            end else begin
               gnt_d = '0;
            end
         end
         BUSY: begin
            // Owner dropping on the last allowed cycle is a normal release.
            if (!bus.req[owner_q] || (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
               gnt_d     = '0;
               ptr_d     = owner_q + ID_W'(1);
               preempt_d = bus.req[owner_q];
               state_d   = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   onehot_enc_4to2 u_enc (
      .onehot_i (gnt_q),
      .idx_c_o  (bus.gnt_id)
   );

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed vector table plus randomized run against a model.
module tb_rr_arbiter_4;

   localparam int unsigned MH    = 2;
   localparam int          BOUND = 4 * (MH + 1) + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rr_arbiter_4_if bus ();

   rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: current owner (-1 when idle), priority pointer, grant age.
   int   m_own = -1;
   int   m_ptr = 0;
   int   m_len = 0;
   logic m_pre = 1'b0;

   int   wait_c [4];
   int   run_len = 0;
   logic [3:0] prev_gnt = 4'b0000;

   typedef struct {
      logic [3:0] req;
      logic       rn;
      logic [3:0] gnt;
      logic       pre;
   } vec_t;

   vec_t tbl [30];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [3:0] g);
      int r = 0;
      for (int i = 0; i < 4; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic model_step(input logic [3:0] r, input logic rn);
      m_pre = 1'b0;
      if (!rn) begin
         m_own = -1;
         m_ptr = 0;
         m_len = 0;
      end else if (m_own < 0) begin
         for (int k = 0; k < 4; k++) begin
            if (m_own < 0 && r[(m_ptr + k) % 4]) begin
               m_own = (m_ptr + k) % 4;
               m_len = 1;
            end
         end
      end else if (!r[m_own] || m_len == int'(MH)) begin
         m_pre = r[m_own];
         m_ptr = (m_own + 1) % 4;
         m_own = -1;
      end else begin
         m_len++;
      end
   endtask

   task automatic compare_model();
      logic [3:0] eg;
      eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
      chk("model_gnt", 32'(bus.gnt), 32'(eg));
      chk("model_gnt_id", 32'(bus.gnt_id), 32'((m_own < 0) ? 0 : m_own));
      chk("model_gnt_valid", 32'(bus.gnt_valid), 32'(m_own >= 0));
      chk("model_preempt", 32'(bus.preempt), 32'(m_pre));
      chk("onehot_or_zero", 32'($countones(bus.gnt) <= 1), 32'd1);
      chk("gnt_id_encodes_gnt", 32'(bus.gnt_id), 32'(idx_of(bus.gnt)));
      if (bus.gnt != 4'b0000 && bus.gnt == prev_gnt) run_len++;
      else if (bus.gnt != 4'b0000) run_len = 1;
      else run_len = 0;
      prev_gnt = bus.gnt;
      chk("max_hold", 32'(run_len <= int'(MH)), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (bus.req[i] && !bus.gnt[i]) wait_c[i]++;
         else wait_c[i] = 0;
         chk("starvation", 32'(wait_c[i] <= BOUND), 32'd1);
      end
   endtask

   task automatic cycle(input logic [3:0] r, input logic rn);
      bus.req = r;
      rst_n   = rn;
      @(posedge clk);
      model_step(r, rn);
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
      bus.req = 4'b0000;
      rst_n   = 1'b0;

      tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0};
      tbl[1]  = '{4'b0110, 1'b1, 4'b0010, 1'b0};
      tbl[2]  = '{4'b0100, 1'b1, 4'b0000, 1'b0};
      tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b0};
      tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b0};
      tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      tbl[7]  = '{4'b1001, 1'b1, 4'b0001, 1'b0};
      tbl[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b0};
      tbl[9]  = '{4'b1000, 1'b1, 4'b0000, 1'b0};
      tbl[10] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
      tbl[11] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
      tbl[12] = '{4'b1000, 1'b1, 4'b0000, 1'b1};
      tbl[13] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
      tbl[14] = '{4'b0100, 1'b1, 4'b0000, 1'b0};
      tbl[15] = '{4'b0100, 1'b1, 4'b0100, 1'b0};
      tbl[16] = '{4'b1111, 1'b0, 4'b0000, 1'b0};
      tbl[17] = '{4'b1111, 1'b1, 4'b0001, 1'b0};
      tbl[18] = '{4'b1111, 1'b1, 4'b0001, 1'b0};
      tbl[19] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
      tbl[20] = '{4'b1111, 1'b1, 4'b0010, 1'b0};
      tbl[21] = '{4'b1111, 1'b1, 4'b0010, 1'b0};
      tbl[22] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
      tbl[23] = '{4'b1111, 1'b1, 4'b0100, 1'b0};
      tbl[24] = '{4'b1111, 1'b1, 4'b0100, 1'b0};
      tbl[25] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
      tbl[26] = '{4'b1111, 1'b1, 4'b1000, 1'b0};
      tbl[27] = '{4'b1111, 1'b1, 4'b1000, 1'b0};
      tbl[28] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
      tbl[29] = '{4'b1111, 1'b1, 4'b0001, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         cycle(tbl[i].req, tbl[i].rn);
         chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d_gnt_id", i), 32'(bus.gnt_id), 32'(idx_of(tbl[i].gnt)));
         chk($sformatf("vec%0d_gnt_valid", i), 32'(bus.gnt_valid), 32'(tbl[i].gnt != 4'b0000));
         chk($sformatf("vec%0d_preempt", i), 32'(bus.preempt), 32'(tbl[i].pre));
      end

      // Requests stay up until served; only the current owner may withdraw.
      r = 4'b0000;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!r[i]) begin
               if ($urandom_range(0, 2) == 0) r[i] = 1'b1;
            end else if (m_own == i && $urandom_range(0, 3) == 0) begin
               r[i] = 1'b0;
            end
         end
         cycle(r, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
